// File: rtl/pic_irq_dispatch_pkg.sv
// Shared PIC definitions: line count, SPR register offsets and the dispatch FSM encoding.
package pic_irq_dispatch_pkg;

    localparam int PIC_INTS = 20;

    localparam logic [1:0] PIC_OFS_PICMR = 2'd0;
    localparam logic [1:0] PIC_OFS_PICSR = 2'd2;
    localparam int         PICOFS_MSB    = 1;
    localparam int         PICOFS_LSB    = 0;

    typedef logic [2:0] pic_state_t;

    localparam pic_state_t ST_IDLE    = 3'd0;
    localparam pic_state_t ST_READ    = 3'd1;
    localparam pic_state_t ST_REQ     = 3'd2;
    localparam pic_state_t ST_CLEAR   = 3'd3;
    localparam pic_state_t ST_SERVICE = 3'd4;

    function automatic logic [31:0] picsr_addr(input logic [31:0] base);
        return base | {30'd0, PIC_OFS_PICSR};
    endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 wins, `any` flags a non-empty request vector.
module pic_prio_enc #(
    parameter int PIC_INTS = 20,
    parameter int ID_W     = 5
) (
    input  logic [PIC_INTS-1:0] req,
    output logic [ID_W-1:0]     id,
    output logic                any
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        id = '0;
        for (int i = PIC_INTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pic_irq_dispatch.sv
// Core-side PIC dispatcher: reads PICSR, requests the exception for the highest-priority
// source, clears its PICSR bit with a same-cycle read-modify-write, then waits for end of service.
module pic_irq_dispatch #(
    parameter int          PIC_INTS = pic_irq_dispatch_pkg::PIC_INTS,
    parameter logic [31:0] PIC_BASE = 32'h0000_4800,
    parameter int          ID_W     = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            irq2core,
    input  logic            core_irq_en,
    input  logic            core_ready,
    output logic            spr_cs,
    output logic            spr_write,
    output logic [31:0]     spr_addr,
    output logic [31:0]     spr_dat_o,
    input  logic [31:0]     spr_dat_i,
    output logic            exc_req,
    output logic [ID_W-1:0] irq_id,
    input  logic            exc_ack,
    input  logic            irq_done,
    output logic            busy,
    output logic [7:0]      spurious_cnt
);

    import pic_irq_dispatch_pkg::pic_state_t;
    import pic_irq_dispatch_pkg::ST_IDLE;
    import pic_irq_dispatch_pkg::ST_READ;
    import pic_irq_dispatch_pkg::ST_REQ;
    import pic_irq_dispatch_pkg::ST_CLEAR;
    import pic_irq_dispatch_pkg::ST_SERVICE;
    import pic_irq_dispatch_pkg::picsr_addr;

    localparam logic [31:0] VALID_MASK = (PIC_INTS >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << PIC_INTS) - 32'd1);

    pic_state_t      state_q, state_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic [7:0]      spurious_cnt_q, spurious_cnt_d;
    logic [ID_W-1:0] enc_id;
    logic            enc_any;
    logic [31:0]     clr_data;

    pic_prio_enc #(
        .PIC_INTS (PIC_INTS),
        .ID_W     (ID_W)
    ) u_prio_enc (
        .req (spr_dat_i[PIC_INTS-1:0]),
        .id  (enc_id),
        .any (enc_any)
    );

    always_comb begin
        state_d        = state_q;
        irq_id_d       = irq_id_q;
        spurious_cnt_d = spurious_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (irq2core && core_irq_en && core_ready) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (enc_any) begin
                    irq_id_d = enc_id;
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                    if (spurious_cnt_q != 8'hFF) begin
                        spurious_cnt_d = spurious_cnt_q + 8'd1;
                    end
                end
            end
            // Once committed the request stands; only the core's ack moves us on.
            ST_REQ: begin
                if (exc_ack) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR:   state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (irq_done) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            irq_id_q       <= '0;
            spurious_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            irq_id_q       <= irq_id_d;
            spurious_cnt_q <= spurious_cnt_d;
        end
    end

    // Live PICSR passes straight through so bits the PIC latches this cycle survive the clear.
    assign clr_data = spr_dat_i & VALID_MASK & ~(32'd1 << irq_id_q);

    assign exc_req      = (state_q == ST_REQ);
    assign busy         = (state_q != ST_IDLE);
    assign spr_cs       = (state_q == ST_READ) || (state_q == ST_CLEAR);
    assign spr_write    = (state_q == ST_CLEAR);
    assign spr_addr     = spr_cs ? picsr_addr(PIC_BASE) : 32'd0;
    assign spr_dat_o    = (state_q == ST_CLEAR) ? clr_data : 32'd0;
    assign irq_id       = irq_id_q;
    assign spurious_cnt = spurious_cnt_q;

endmodule

// File: tb/tb_pic_irq_dispatch.sv
// Bench for pic_irq_dispatch: a small PICSR model plus a scoreboard of expected (irq_id, clear word).
module tb_pic_irq_dispatch;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] clr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        irq2core;
    logic        core_irq_en;
    logic        core_ready;
    logic        spr_cs;
    logic        spr_write;
    logic [31:0] spr_addr;
    logic [31:0] spr_dat_o;
    logic [31:0] spr_dat_i;
    logic        exc_req;
    logic [4:0]  irq_id;
    logic        exc_ack;
    logic        irq_done;
    logic        busy;
    logic [7:0]  spurious_cnt;

    logic [19:0] picsr;
    logic [19:0] inject;
    logic [19:0] load_val;
    logic        load_en;
    logic        irq_manual;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    pic_irq_dispatch #(
        .PIC_INTS (20),
        .PIC_BASE (32'h0000_4800),
        .ID_W     (5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .irq2core     (irq2core),
        .core_irq_en  (core_irq_en),
        .core_ready   (core_ready),
        .spr_cs       (spr_cs),
        .spr_write    (spr_write),
        .spr_addr     (spr_addr),
        .spr_dat_o    (spr_dat_o),
        .spr_dat_i    (spr_dat_i),
        .exc_req      (exc_req),
        .irq_id       (irq_id),
        .exc_ack      (exc_ack),
        .irq_done     (irq_done),
        .busy         (busy),
        .spurious_cnt (spurious_cnt)
    );

    initial forever #5 clock = ~clock;

    // PIC side: PICSR keeps its bits across dispatcher resets; newly latched bits OR in.
    always @(posedge clock) begin
        if (load_en) begin
            picsr <= load_val;
        end else if (spr_cs && spr_write) begin
            picsr <= spr_dat_o[19:0] | inject;
        end else begin
            picsr <= picsr | inject;
        end
    end

    assign spr_dat_i = {12'd0, picsr};
    assign irq2core  = (|picsr) | irq_manual;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic load(input logic [19:0] v);
        load_val = v;
        load_en  = 1'b1;
        @(negedge clock);
        load_en  = 1'b0;
    endtask

    task automatic push_exp(input logic [4:0] id, input logic [31:0] clr);
        exp_t e;
        e.id  = id;
        e.clr = clr;
        sb_q.push_back(e);
    endtask

    task automatic pop_and_check_id();
        exp_t e;
        check_val("sb_pending", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("irq_id", 32'(irq_id), 32'(e.id));
        end
    endtask

    task automatic wait_req();
        int i;
        i = 0;
        while (!exc_req && i < 50) begin
            @(negedge clock);
            i++;
        end
        check_val("req_seen", 32'(exc_req), 1);
    endtask

    // Full handshake for one source; 'inj' models bits the PIC latches during CLEAR.
    task automatic dispatch(input int ack_dly, input logic [19:0] inj);
        exp_t e;
        int   i;
        i = 0;
        while (!spr_cs && i < 50) begin
            @(negedge clock);
            i++;
        end
        check_val("read_cs", 32'(spr_cs), 1);
        check_val("read_we", 32'(spr_write), 0);
        check_val("read_addr", spr_addr, 32'h4802);
        @(negedge clock);
        check_val("req", 32'(exc_req), 1);
        check_val("sb_pending", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_val("irq_id", 32'(irq_id), 32'(e.id));
        repeat (ack_dly) @(negedge clock);
        check_val("req_hold", {26'd0, exc_req, irq_id}, {26'd0, 1'b1, e.id});
        exc_ack = 1'b1;
        @(negedge clock);
        exc_ack = 1'b0;
        inject  = inj;
        check_val("clr_cs_we", {30'd0, spr_cs, spr_write}, 32'h3);
        check_val("clr_addr", spr_addr, 32'h4802);
        check_val("clr_data", spr_dat_o, e.clr);
        @(negedge clock);
        inject = '0;
        check_val("svc", {29'd0, busy, exc_req, spr_cs}, 32'h4);
        irq_done = 1'b1;
        @(negedge clock);
        irq_done = 1'b0;
        check_val("idle", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        core_irq_en = 1'b1;
        core_ready  = 1'b1;
        exc_ack     = 1'b0;
        irq_done    = 1'b0;
        irq_manual  = 1'b0;
        inject      = '0;
        load_en     = 1'b0;
        load_val    = '0;
        load(20'h0);
        @(negedge clock);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_req", 32'(exc_req), 0);
        check_val("rst_spr", {30'd0, spr_cs, spr_write}, 0);
        check_val("rst_id", 32'(irq_id), 0);
        check_val("rst_spur", 32'(spurious_cnt), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single source 4, ack one cycle after the request.
        load(20'h00010);
        push_exp(5'd4, 32'h0);
        dispatch(0, 20'h0);

        // Three sources dispatched in priority order.
        load(20'h80006);
        push_exp(5'd1, 32'h80004);
        push_exp(5'd2, 32'h80000);
        push_exp(5'd19, 32'h0);
        dispatch(1, 20'h0);
        dispatch(0, 20'h0);
        dispatch(2, 20'h0);

        // Bit 7 latched while source 3 is being cleared must survive.
        load(20'h00008);
        push_exp(5'd3, 32'h0);
        dispatch(0, 20'h00080);
        check_val("picsr_after_rmw", 32'(picsr), 32'h80);
        push_exp(5'd7, 32'h0);
        dispatch(0, 20'h0);

        // Spurious reads: empty PICSR, count and saturate.
        irq_manual = 1'b1;
        @(negedge clock);
        check_val("spur_read", 32'(spr_cs), 1);
        irq_manual = 1'b0;
        @(negedge clock);
        check_val("spur_noreq", {30'd0, exc_req, busy}, 0);
        check_val("spur_cnt1", 32'(spurious_cnt), 1);
        for (int n = 2; n <= 300; n++) begin
            irq_manual = 1'b1;
            @(negedge clock);
            irq_manual = 1'b0;
            @(negedge clock);
            if (n == 254) check_val("spur_cnt254", 32'(spurious_cnt), 254);
            if (n == 255) check_val("spur_cnt255", 32'(spurious_cnt), 255);
        end
        check_val("spur_sat", 32'(spurious_cnt), 255);

        // Gating by core enable / ready.
        core_irq_en = 1'b0;
        load(20'h00004);
        repeat (4) @(negedge clock);
        check_val("gate_en", {30'd0, spr_cs, busy}, 0);
        core_irq_en = 1'b1;
        core_ready  = 1'b0;
        repeat (4) @(negedge clock);
        check_val("gate_rdy", {30'd0, spr_cs, busy}, 0);
        core_ready = 1'b1;
        @(negedge clock);
        check_val("gate_release", 32'(spr_cs), 1);
        push_exp(5'd2, 32'h0);
        dispatch(0, 20'h0);

        // Reset while requesting: outputs drop at once, source is re-dispatched.
        load(20'h00020);
        push_exp(5'd5, 32'h0);
        wait_req();
        pop_and_check_id();
        #2 reset_n = 1'b0;
        #1;
        check_val("rreq_outs", {27'd0, exc_req, busy, spr_cs, spr_write, 1'b0}, 0);
        check_val("rreq_id", 32'(irq_id), 0);
        check_val("rreq_spur", 32'(spurious_cnt), 0);
        @(negedge clock);
        reset_n = 1'b1;
        push_exp(5'd5, 32'h0);
        dispatch(0, 20'h0);

        // Reset during the clear cycle: the write is dropped, the bit stays pending.
        load(20'h00040);
        push_exp(5'd6, 32'h0);
        wait_req();
        pop_and_check_id();
        exc_ack = 1'b1;
        @(negedge clock);
        exc_ack = 1'b0;
        check_val("rclr_in_clear", {30'd0, spr_cs, spr_write}, 32'h3);
        #2 reset_n = 1'b0;
        #1;
        check_val("rclr_ctl", {29'd0, spr_cs, spr_write, busy}, 0);
        check_val("rclr_addr", spr_addr, 0);
        check_val("rclr_data", spr_dat_o, 0);
        @(negedge clock);
        check_val("rclr_pending", 32'(picsr), 32'h40);
        reset_n = 1'b1;
        push_exp(5'd6, 32'h0);
        dispatch(1, 20'h0);

        check_val("sb_drained", 32'(sb_q.size()), 0);
        check_val("picsr_empty", 32'(picsr), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
